mux_select_rr_arbiter: RTL

// Round-robin arbiter that shares one 8:1 single-bit multiplexer between 8 requesters.

---
 rtl/mux_ctrl_pkg.sv | 15 +
 rtl/rr_pick8.sv | 29 ++
 rtl/mux_select_rr_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared types and constants for the mux select round-robin arbiter.
package mux_ctrl_pkg;

  localparam int N_LINES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo 8.
module rr_pick8
  import mux_ctrl_pkg::*;
(
  input  logic [N_LINES-1:0] req,
  input  sel_t               ptr,
  output logic               found,
  output sel_t               idx
);

  logic [2*N_LINES-1:0] dbl;
  logic [N_LINES-1:0]   rot;
  sel_t                 enc;

  // Rotate so that bit ptr lands at position 0, find the lowest set bit,
  // then undo the rotation by adding ptr back (3-bit wrap).
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_LINES-1:0];
    enc = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (rot[i]) enc = sel_t'(i);
    end
    found = |req;
    idx   = enc + ptr;
  end

endmodule

// File: rtl/mux_select_rr_arbiter.sv
// Round-robin arbiter driving the select port of an 8:1 mux. One requester
// owns the mux for a burst of at most MAX_HOLD cycles, then priority rotates
// past it and GAP_CYCLES dead cycles follow before the next arbitration.
//
// Handshake: req[i] is a level request. A grant is issued from IDLE only;
// while granted, dropping req[idx] releases the mux at the next edge.
// Other requests are not looked at until the block is back in IDLE.
module mux_select_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_HOLD   = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LINES-1:0] req,
  output logic [SEL_W-1:0]   select_lines,
  output logic [N_LINES-1:0] grant,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [1:0] GAP_LAST  = 2'(GAP_CYCLES - 1);

  arb_state_t state;
  sel_t       ptr;
  logic [3:0] hold_cnt;
  logic [1:0] gap_cnt;
  logic       pick_found;
  sel_t       pick_idx;
  logic       release_now;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // select_lines doubles as the current owner index while granted.
  assign release_now = !req[select_lines] || (hold_cnt == HOLD_LAST);
  assign state_dbg   = state;

  // Arbitration FSM with registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      select_lines <= '0;
      busy         <= 1'b0;
      ptr          <= '0;
      hold_cnt     <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant        <= N_LINES'(1) << pick_idx;
            select_lines <= pick_idx;
            busy         <= 1'b1;
            hold_cnt     <= '0;
            state        <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            // A request drop coinciding with hold expiry is one release.
            grant    <= '0;
            busy     <= 1'b0;
            ptr      <= select_lines + 3'd1;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            state    <= (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        ARB_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ARB_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 2'd1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
